countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter ALARM_SECS, default 10: number of en_1hz ticks that alarm stays high after expiry.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 cr  input  1  reset, synchronous, active-high.
REQ-004 en_1hz  input  1  one-cycle-wide 1 Hz tick, synchronous to clk.
REQ-005 load  input  1  one-cycle strobe; capture load_val.
REQ-006 load_val  input  16  BCD {min_t, min_u, sec_t, sec_u}, 4 bits each.
REQ-007 start  input  1  one-cycle strobe; begin or resume countdown.
REQ-008 pause  input  1  one-cycle strobe; suspend countdown.
REQ-009 out  output  16  current BCD value {min_t, min_u, sec_t, sec_u}.
REQ-010 busy  output  1  high in RUN or PAUSE.
REQ-011 done  output  1  one-cycle pulse on reaching 00:00.
REQ-012 alarm  output  1  high while in DONE.
REQ-013 load_err  output  1  one-cycle pulse on a rejected load.

Function
REQ-014 States: IDLE, RUN, PAUSE, DONE, encoded 2 bits.
REQ-015 Legal load_val: min_t and sec_t 0-5, min_u and sec_u 0-9; any other digit rejects the whole load.
REQ-016 A rejected load leaves out and state unchanged and pulses load_err for 1 cycle.
REQ-017 A legal load in IDLE, PAUSE or DONE updates out on the next edge, clears alarm and sets state to IDLE.
REQ-018 load in RUN is ignored, with no load_err.
REQ-019 Input priority on the same edge: cr > load > start > pause.
REQ-020 start in IDLE with out != 0000 goes to RUN; start in IDLE with out == 0000 is ignored.
REQ-021 start in PAUSE returns to RUN, and out is unchanged.
REQ-022 start in DONE clears alarm and goes to IDLE with out = 0000.
REQ-023 pause in RUN goes to PAUSE; pause in any other state is ignored.
REQ-024 In RUN, each en_1hz decrements out by one second, BCD with borrow:
  - sec_u 0 wraps to 9 and borrows from sec_t;
  - sec_t 0 wraps to 5 and borrows from min_u;
  - min_u 0 wraps to 9 and borrows from min_t.
REQ-025 en_1hz on the same edge as a start or pause transition is not applied; the first decrement happens on the next tick in RUN.
REQ-026 A tick in RUN with out == 0001 sets out = 0000 and state = DONE, with done high the following cycle only.
REQ-027 out == 0000 is never decremented, so there is no wrap to 5959.
REQ-028 In DONE, alarm stays high; after ALARM_SECS en_1hz ticks in DONE, the block goes to IDLE and alarm drops.
REQ-029 Maximum value is 5959, minimum is 0000; out never holds a non-BCD digit.
REQ-030 All outputs are registered; latency from any strobe to its effect on out or state is exactly 1 cycle.

Reset
REQ-031 cr high on a rising edge forces:
  - state IDLE, out 0000;
  - busy, done, alarm and load_err 0;
  - alarm tick counter 0.
REQ-032 cr overrides all other inputs on the same edge, including mid-RUN and mid-DONE.
REQ-033 After cr drops, the block waits for load/start; nothing auto-runs.

Structure
REQ-034 A shared package holds:
  - state encoding constants (IDLE, RUN, PAUSE, DONE);
  - digit limit constants TENS_MAX = 5, UNITS_MAX = 9;
  - ALARM_SECS default.
REQ-035 One sub-module, bcd_down_digit, is instantiated 4 times.
  - Parameter: digit maximum.
  - Ports: clk, cr, load, load_digit, dec, q[3:0], borrow_out.
  - borrow_out is high when dec is asserted and q == 0.
REQ-036 The borrow chain is combinational from sec_u to min_t, gated by RUN and en_1hz.

Verification
REQ-037 Load 0003, start, 3 ticks:
  - out steps 0002, 0001, 0000;
  - done pulses 1 cycle after the third tick;
  - alarm high for 10 ticks, then IDLE.
REQ-038 Load 1000, start, 1 tick: out = 0959. Then load 0100, start, 1 tick: out = 0059.
REQ-039 Load 0A00: load_err pulses 1 cycle; out keeps its prior value; state unchanged.
REQ-040 Load 0010, start, 2 ticks, then pause and tick on the same edge:
  - out = 0008 and holds across 3 further ticks;
  - start plus 1 tick gives 0007.
REQ-041 Load 5959, start, 1 tick: out = 5958. Then assert cr mid-RUN: next cycle out = 0000, busy = 0, state IDLE.
REQ-042 start with out = 0000 is ignored (busy stays 0). load and start on the same edge: load wins, state IDLE.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the BCD mm:ss countdown timer: state encoding,
// per-digit limits and the default alarm duration.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] TENS_MAX       = 4'd5;
  localparam logic [3:0] UNITS_MAX      = 4'd9;
  localparam int         ALARM_SECS_DEF = 10;

  // A load is only accepted when every digit is within its own limit.
  function automatic logic bcd_time_legal(input logic [15:0] v);
    return (v[15:12] <= TENS_MAX) && (v[11:8] <= UNITS_MAX) &&
           (v[7:4]   <= TENS_MAX) && (v[3:0]  <= UNITS_MAX);
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit that wraps from 0 to DIGIT_MAX.
// borrow_out flags that this decrement wraps and must ripple to the next digit.
module bcd_down_digit
  import countdown_timer_pkg::*;
#(
  parameter logic [3:0] DIGIT_MAX = UNITS_MAX
) (
  input  logic       clk,
  input  logic       cr,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       dec,
  output logic [3:0] q,
  output logic       borrow_out
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_digit;
    end else if (dec) begin
      q_d = (q_q == 4'd0) ? DIGIT_MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (cr) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q          = q_q;
  assign borrow_out = dec & (q_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// mm:ss BCD countdown timer with load/start/pause strobes, a one-cycle done
// pulse and an alarm that holds for ALARM_SECS ticks; all outputs registered.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int ALARM_SECS = ALARM_SECS_DEF
) (
  input  logic        clk,
  input  logic        cr,
  input  logic        en_1hz,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] out,
  output logic        busy,
  output logic        done,
  output logic        alarm,
  output logic        load_err
);

  localparam int CNT_W = (ALARM_SECS < 2) ? 1 : $clog2(ALARM_SECS + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, done_q, alarm_q, load_err_q;
  logic               done_d, load_err_d;

  logic               digits_load;
  logic [15:0]        digits_bus;
  logic               run_tick;
  logic [3:0]         q_secu, q_sect, q_minu, q_mint;
  logic               b_secu, b_sect, b_minu, borrow_unused;
  logic               out_zero;

  assign out      = {q_mint, q_minu, q_sect, q_secu};
  assign out_zero = (out == 16'h0000);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    load_err_d  = 1'b0;
    digits_load = 1'b0;
    digits_bus  = load_val;
    run_tick    = 1'b0;

    // A load outside RUN claims the edge whether or not it is legal.
    if (load && state_q != ST_RUN) begin
      if (bcd_time_legal(load_val)) begin
        digits_load = 1'b1;
        state_d     = ST_IDLE;
        cnt_d       = '0;
      end else begin
        load_err_d  = 1'b1;
      end
    end else if (start && state_q == ST_IDLE && !out_zero) begin
      state_d = ST_RUN;
    end else if (start && state_q == ST_PAUSE) begin
      state_d = ST_RUN;
    end else if (start && state_q == ST_DONE) begin
      digits_load = 1'b1;
      digits_bus  = 16'h0000;
      state_d     = ST_IDLE;
      cnt_d       = '0;
    end else if (pause && state_q == ST_RUN) begin
      state_d = ST_PAUSE;
    end else if (en_1hz) begin
      case (state_q)
        ST_RUN: begin
          run_tick = !out_zero;
          if (out == 16'h0001) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end
        end
        ST_DONE: begin
          if (cnt_q == CNT_W'(ALARM_SECS - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cr) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      alarm_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= (state_d == ST_RUN) || (state_d == ST_PAUSE);
      done_q     <= done_d;
      alarm_q    <= (state_d == ST_DONE);
      load_err_q <= load_err_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign alarm    = alarm_q;
  assign load_err = load_err_q;

  bcd_down_digit #(.DIGIT_MAX(UNITS_MAX)) u_sec_u (
    .clk(clk), .cr(cr), .load(digits_load), .load_digit(digits_bus[3:0]),
    .dec(run_tick), .q(q_secu), .borrow_out(b_secu)
  );

  bcd_down_digit #(.DIGIT_MAX(TENS_MAX)) u_sec_t (
    .clk(clk), .cr(cr), .load(digits_load), .load_digit(digits_bus[7:4]),
    .dec(b_secu), .q(q_sect), .borrow_out(b_sect)
  );

  bcd_down_digit #(.DIGIT_MAX(UNITS_MAX)) u_min_u (
    .clk(clk), .cr(cr), .load(digits_load), .load_digit(digits_bus[11:8]),
    .dec(b_sect), .q(q_minu), .borrow_out(b_minu)
  );

  // Decrement never runs from 0000, so the top digit's borrow is never taken.
  bcd_down_digit #(.DIGIT_MAX(TENS_MAX)) u_min_t (
    .clk(clk), .cr(cr), .load(digits_load), .load_digit(digits_bus[15:12]),
    .dec(b_minu), .q(q_mint), .borrow_out(borrow_unused)
  );

endmodule

// File: tb/tb_countdown_timer.sv
// Directed and randomized checks of countdown_timer against a seconds-based
// reference model.
module tb_countdown_timer;

  logic        clk;
  logic        cr;
  logic        en_1hz;
  logic        load;
  logic [15:0] load_val;
  logic        start;
  logic        pause;
  logic [15:0] out;
  logic        busy;
  logic        done;
  logic        alarm;
  logic        load_err;

  int total = 0;
  int bad   = 0;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;
  localparam int M_ALARM = 10;

  int m_secs = 0;
  int m_st   = M_IDLE;
  int m_acnt = 0;
  bit m_done = 1'b0;
  bit m_err  = 1'b0;

  countdown_timer #(.ALARM_SECS(M_ALARM)) dut (
    .clk(clk), .cr(cr), .en_1hz(en_1hz), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .out(out), .busy(busy), .done(done),
    .alarm(alarm), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int s);
    int m;
    int sc;
    m  = s / 60;
    sc = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  function automatic bit legal(input logic [15:0] v);
    return int'(v[15:12]) < 6 && int'(v[11:8]) < 10 &&
           int'(v[7:4]) < 6 && int'(v[3:0]) < 10;
  endfunction

  function automatic int bcd2s(input logic [15:0] v);
    return 600 * int'(v[15:12]) + 60 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit c, input bit l, input logic [15:0] lv,
                       input bit s, input bit p, input bit t);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (c) begin
      m_secs = 0; m_st = M_IDLE; m_acnt = 0;
    end else if (l && m_st != M_RUN) begin
      if (legal(lv)) begin
        m_secs = bcd2s(lv); m_st = M_IDLE; m_acnt = 0;
      end else begin
        m_err = 1'b1;
      end
    end else if (s && m_st == M_IDLE && m_secs != 0) begin
      m_st = M_RUN;
    end else if (s && m_st == M_PAUSE) begin
      m_st = M_RUN;
    end else if (s && m_st == M_DONE) begin
      m_secs = 0; m_st = M_IDLE; m_acnt = 0;
    end else if (p && m_st == M_RUN) begin
      m_st = M_PAUSE;
    end else if (t && m_st == M_RUN) begin
      m_secs = m_secs - 1;
      if (m_secs == 0) begin
        m_st = M_DONE; m_done = 1'b1; m_acnt = 0;
      end
    end else if (t && m_st == M_DONE) begin
      m_acnt = m_acnt + 1;
      if (m_acnt == M_ALARM) begin
        m_st = M_IDLE; m_acnt = 0;
      end
    end
  endtask

  task automatic step(input bit c, input bit l, input logic [15:0] lv,
                      input bit s, input bit p, input bit t);
    cr = c; load = l; load_val = lv; start = s; pause = p; en_1hz = t;
    model(c, l, lv, s, p, t);
    @(posedge clk);
    #1;
    cr = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; en_1hz = 1'b0;
    check("out", out, to_bcd(m_secs));
    check("busy", {15'd0, busy}, {15'd0, (m_st == M_RUN || m_st == M_PAUSE)});
    check("alarm", {15'd0, alarm}, {15'd0, (m_st == M_DONE)});
    check("done", {15'd0, done}, {15'd0, m_done});
    check("load_err", {15'd0, load_err}, {15'd0, m_err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_load(input logic [15:0] v);
    step(1'b0, 1'b1, v, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_pause();
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_cr();
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] lv;
    bit          c, l, s, p, t;

    cr = 1'b0; load = 1'b0; load_val = 16'h0; start = 1'b0; pause = 1'b0; en_1hz = 1'b0;

    // Reset state, then no auto-run on idle ticks.
    do_cr();
    check("rst_out", out, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    tick(2);
    check("idle_no_run", out, 16'h0000);

    // Short countdown into DONE and alarm timeout.
    do_load(16'h0003);
    do_start();
    check("r37_busy", {15'd0, busy}, 16'd1);
    tick(1);
    check("r37_t1", out, 16'h0002);
    tick(1);
    check("r37_t2", out, 16'h0001);
    tick(1);
    check("r37_t3", out, 16'h0000);
    check("r37_done", {15'd0, done}, 16'd1);
    check("r37_alarm", {15'd0, alarm}, 16'd1);
    idle(1);
    check("r37_done_off", {15'd0, done}, 16'd0);
    tick(9);
    check("r37_alarm_9", {15'd0, alarm}, 16'd1);
    tick(1);
    check("r37_alarm_10", {15'd0, alarm}, 16'd0);

    // Borrow across digits.
    do_load(16'h1000);
    do_start();
    tick(1);
    check("r38_0959", out, 16'h0959);
    do_pause();
    do_load(16'h0100);
    do_start();
    tick(1);
    check("r38_0059", out, 16'h0059);

    // Load in RUN is ignored, illegal load while paused is rejected.
    do_load(16'h0123);
    check("r18_ign", out, 16'h0059);
    check("r18_noerr", {15'd0, load_err}, 16'd0);
    do_pause();
    do_load(16'h0A00);
    check("r39_err", {15'd0, load_err}, 16'd1);
    check("r39_out", out, 16'h0059);
    check("r39_busy", {15'd0, busy}, 16'd1);
    idle(1);
    check("r39_err_off", {15'd0, load_err}, 16'd0);

    // Pause with a coincident tick, hold, then resume.
    do_load(16'h0010);
    do_start();
    tick(2);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    check("r40_pause", out, 16'h0008);
    tick(3);
    check("r40_hold", out, 16'h0008);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    check("r40_start_tick", out, 16'h0008);
    tick(1);
    check("r40_resume", out, 16'h0007);

    // Maximum value and cr mid-RUN.
    do_pause();
    do_load(16'h5959);
    do_start();
    tick(1);
    check("r41_5958", out, 16'h5958);
    do_cr();
    check("r41_cr_out", out, 16'h0000);
    check("r41_cr_busy", {15'd0, busy}, 16'd0);

    // start at zero ignored; load beats start.
    do_start();
    check("r42_zero_start", {15'd0, busy}, 16'd0);
    step(1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0);
    check("r42_load_wins", {15'd0, busy}, 16'd0);
    check("r42_load_out", out, 16'h0005);

    // cr mid-DONE, and start from DONE.
    do_load(16'h0001);
    do_start();
    tick(1);
    tick(3);
    do_cr();
    check("cr_done_alarm", {15'd0, alarm}, 16'd0);
    do_load(16'h0001);
    do_start();
    tick(1);
    do_start();
    check("done_start_alarm", {15'd0, alarm}, 16'd0);
    check("done_start_out", out, 16'h0000);

    // Randomized traffic checked by the reference model.
    for (int i = 0; i < 3000; i++) begin
      c = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 19) == 0);
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 11) == 0);
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin
        lv = 16'($urandom);
      end else if ($urandom_range(0, 2) != 0) begin
        lv = to_bcd(int'($urandom_range(0, 40)));
      end else begin
        lv = to_bcd(int'($urandom_range(0, 3599)));
      end
      step(c, l, lv, s, p, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
